// File: rtl/bus_protocol_pkg.sv
// Shared types and default parameters for the bus master arbiter.
//   bm_state_t   : transfer FSM states (IDLE -> XFER -> GAP -> IDLE)
//   N_DEF        : default requester count
//   DW_DEF       : default bus data width
//   MIN_CYC_DEF  : default minimum dValid-high cycles before an ack is accepted
//   MAX_CYC_DEF  : default dValid-high cycles before a transfer times out
package bus_protocol_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } bm_state_t;

    localparam int unsigned N_DEF       = 4;
    localparam int unsigned DW_DEF      = 8;
    localparam int unsigned MIN_CYC_DEF = 2;
    localparam int unsigned MAX_CYC_DEF = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   req : N request levels
//   ptr : index of the last served requester; the search starts just after it
//   win : one-hot winner, all zero when no request is set
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win
);

    logic [PW-1:0] idx;
    logic          found;

    // Walk ptr+1 .. ptr+N modulo N and take the first set request.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned off = 1; off <= N; off++) begin
            idx = PW'((32'(ptr) + off) % N);
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_master_arbiter.sv
// Sole master of the dValid/dAck/data bus, shared round-robin between N requesters.
//   clk, reset_n : clock and asynchronous active-low reset
//   req          : per-requester pending-word levels
//   req_data     : word of requester i at [i*DW +: DW]
//   gnt          : one-hot, high for the whole transfer of the granted requester
//   done         : one-cycle pulse to the requester whose transfer just ended
//   err_to       : one-cycle pulse with done when the transfer ended by timeout
//   err_early    : one-cycle pulse when dAck rose in dValid cycle 1 (ack ignored)
//   dAck         : target acknowledge
//   dValid, data : bus valid and bus data
module bus_master_arbiter
    import bus_protocol_pkg::*;
#(
    parameter int unsigned N       = N_DEF,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned MIN_CYC = MIN_CYC_DEF,
    parameter int unsigned MAX_CYC = MAX_CYC_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] req_data,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    done,
    output logic            err_to,
    output logic            err_early,
    input  logic            dAck,
    output logic            dValid,
    output logic [DW-1:0]   data
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    bm_state_t     state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          dack_q;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] cur_q, cur_d;

    logic [N-1:0]  gnt_d, done_d;
    logic          err_to_d, err_early_d, dvalid_d;
    logic [DW-1:0] data_d;

    logic [N-1:0]  win;
    logic [PW-1:0] win_idx;
    logic          ack_rise;

    assign ack_rise = dAck & ~dack_q;

    rr_arbiter #(.N(N), .PW(PW)) u_rr (
        .req (req),
        .ptr (ptr_q),
        .win (win)
    );

    // One-hot winner to index.
    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (win[i]) win_idx = PW'(i);
        end
    end

    // State and output registers; reset gives requester 0 first priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dack_q    <= 1'b0;
            ptr_q     <= PW'(N - 1);
            cur_q     <= '0;
            gnt       <= '0;
            done      <= '0;
            err_to    <= 1'b0;
            err_early <= 1'b0;
            dValid    <= 1'b0;
            data      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dack_q    <= dAck;
            ptr_q     <= ptr_d;
            cur_q     <= cur_d;
            gnt       <= gnt_d;
            done      <= done_d;
            err_to    <= err_to_d;
            err_early <= err_early_d;
            dValid    <= dvalid_d;
            data      <= data_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        cur_d       = cur_q;
        gnt_d       = gnt;
        done_d      = '0;
        err_to_d    = 1'b0;
        err_early_d = 1'b0;
        dvalid_d    = dValid;
        data_d      = data;

        case (state_q)
            IDLE: begin
                dvalid_d = 1'b0;
                if (|req) begin
                    cur_d    = win_idx;
                    gnt_d    = win;
                    dvalid_d = 1'b1;
                    data_d   = req_data[int'(win_idx)*DW +: DW];
                    cnt_d    = 3'd1;
                    state_d  = XFER;
                end
            end

            XFER: begin
                if (ack_rise && (cnt_q >= 3'(MIN_CYC))) begin
                    dvalid_d = 1'b0;
                    gnt_d    = '0;
                    done_d   = gnt;
                    ptr_d    = cur_q;
                    state_d  = GAP;
                end else begin
                    // An ack before MIN_CYC is flagged but does not end the transfer.
                    err_early_d = ack_rise;
                    if (cnt_q >= 3'(MAX_CYC)) begin
                        dvalid_d = 1'b0;
                        gnt_d    = '0;
                        done_d   = gnt;
                        err_to_d = 1'b1;
                        ptr_d    = cur_q;
                        state_d  = GAP;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            // One dead cycle so every transfer starts with a fresh dValid rise.
            GAP: begin
                dvalid_d = 1'b0;
                state_d  = IDLE;
            end

            default: begin
                dvalid_d = 1'b0;
                gnt_d    = '0;
                state_d  = IDLE;
            end
        endcase
    end

endmodule
